// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer and lock supervisor on the reference clock.
// Drives PLL reset, qualifies extlock and produces system reset/ready.
module pll_rst_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRY           = 4,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       lock_fail,
  output logic [7:0] relock_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX =
    RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [RW-1:0]    retry_q;
  logic [RW-1:0]    retry_d;
  logic [7:0]       relock_d;
  logic             lock_m;
  logic             lock_s;
  logic             retry_inc;
  logic             retry_clr;
  logic             relock_inc;
  logic             pll_reset_d;
  logic             run_d;
  logic             lock_fail_d;

  always_ff @(posedge refclk) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= extlock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q    <= RST_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      relock_cnt <= 8'd0;
      lock_fail  <= 1'b0;
      pll_reset  <= 1'b1;
      sys_rst    <= 1'b1;
      pll_ready  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      relock_cnt <= relock_d;
      lock_fail  <= lock_fail_d;
      pll_reset  <= pll_reset_d;
      sys_rst    <= ~run_d;
      pll_ready  <= run_d;
    end
  end

  // lock_s wins over a coincident timeout in WAIT_LOCK
  always_comb begin
    state_d    = state_q;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    relock_inc = 1'b0;
    unique case (state_q)
      RST_PLL: begin
        if (cnt_q == RST_LAST)
          state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = RST_PLL;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d   = RUN;
          retry_clr = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d    = RST_PLL;
          relock_inc = 1'b1;
        end
      end
      default: state_d = RST_PLL;
    endcase
  end

  // next-cycle register values, so outputs move with the state
  always_comb begin
    pll_reset_d = (state_d == RST_PLL);
    run_d       = (state_d == RUN);
    retry_d     = retry_q;
    relock_d    = relock_cnt;
    if (retry_clr)
      retry_d = '0;
    else if (retry_inc && retry_q != RETRY_MAX)
      retry_d = retry_q + 1'b1;
    if (relock_inc && relock_cnt != 8'hff)
      relock_d = relock_cnt + 8'd1;
    lock_fail_d = lock_fail |
      (retry_inc && retry_d == RETRY_MAX);
    if (state_d != state_q)
      cnt_d = '0;
    else if (cnt_q == {CNT_W{1'b1}})
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scenario bench for pll_rst_ctrl with short cycle parameters.
// Expected edges and counts are queued and compared as they occur.
module tb_pll_rst_ctrl;

  logic       refclk = 1'b0;
  logic       reset;
  logic       extlock;
  logic       pll_reset;
  logic       sys_rst;
  logic       pll_ready;
  logic       lock_fail;
  logic [7:0] relock_cnt;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  pll_rst_ctrl #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRY          (2),
    .CNT_W              (17)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .extlock   (extlock),
    .pll_reset (pll_reset),
    .sys_rst   (sys_rst),
    .pll_ready (pll_ready),
    .lock_fail (lock_fail),
    .relock_cnt(relock_cnt)
  );

  always #20 refclk = ~refclk;

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic start(input logic lk);
    reset   = 1'b1;
    extlock = lk;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int cyc);
    cyc = 0;
    while (pll_ready !== 1'b1 && cyc < budget) begin
      tick;
      cyc++;
    end
    if (pll_ready !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    logic [11:0] got;
    reset   = 1'b1;
    extlock = 1'b1;
    tick;
    tick;
    got = {pll_reset, sys_rst, pll_ready, lock_fail, relock_cnt};
    total++;
    if (got !== {4'b1100, 8'd0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", got, {4'b1100, 8'd0});
    end
  endtask

  task automatic test_clean_start;
    int f_pll = -1;
    int f_rst = -1;
    int r_rdy = -1;
    int e;
    logic [11:0] got;
    start(1'b1);
    exp_q.push_back(4);
    exp_q.push_back(13);
    exp_q.push_back(13);
    for (int k = 1; k <= 30; k++) begin
      tick;
      if (f_pll < 0 && pll_reset === 1'b0) f_pll = k;
      if (f_rst < 0 && sys_rst === 1'b0) f_rst = k;
      if (r_rdy < 0 && pll_ready === 1'b1) r_rdy = k;
    end
    e = exp_q.pop_front();
    total++;
    if (f_pll != e) begin
      bad++;
      $display("FAIL clean_pll_reset_width got=%0d want=%0d", f_pll, e);
    end
    e = exp_q.pop_front();
    total++;
    if (f_rst != e) begin
      bad++;
      $display("FAIL clean_sys_rst_fall got=%0d want=%0d", f_rst, e);
    end
    e = exp_q.pop_front();
    total++;
    if (r_rdy != e) begin
      bad++;
      $display("FAIL clean_ready_rise got=%0d want=%0d", r_rdy, e);
    end
    got = {pll_reset, sys_rst, pll_ready, lock_fail, relock_cnt};
    total++;
    if (got !== {4'b0010, 8'd0}) begin
      bad++;
      $display("FAIL clean_status got=%h want=%h", got, {4'b0010, 8'd0});
    end
  endtask

  task automatic test_glitch;
    int f_rst = -1;
    int pr_hi = 0;
    int e;
    start(1'b1);
    for (int k = 1; k <= 9; k++) tick;
    extlock = 1'b0;
    tick;
    extlock = 1'b1;
    exp_q.push_back(21);
    for (int k = 11; k <= 40; k++) begin
      tick;
      if (f_rst < 0 && sys_rst === 1'b0) f_rst = k;
      if (pll_reset !== 1'b0) pr_hi++;
    end
    e = exp_q.pop_front();
    total++;
    if (f_rst != e) begin
      bad++;
      $display("FAIL glitch_run_edge got=%0d want=%0d", f_rst, e);
    end
    total++;
    if (pr_hi != 0) begin
      bad++;
      $display("FAIL glitch_no_pll_reset got=%0d want=0", pr_hi);
    end
    total++;
    if ({lock_fail, relock_cnt} !== 9'd0) begin
      bad++;
      $display("FAIL glitch_counters got=%b/%0d want=0/0",
               lock_fail, relock_cnt);
    end
  endtask

  task automatic test_no_lock;
    logic prev = 1'b1;
    int   rise = 0;
    int   lf   = -1;
    int   rst_lo = 0;
    int   e;
    start(1'b0);
    exp_q.push_back(36);
    exp_q.push_back(72);
    exp_q.push_back(108);
    exp_q.push_back(144);
    for (int k = 1; k <= 150; k++) begin
      tick;
      if (pll_reset === 1'b1 && prev === 1'b0) begin
        rise = k;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        total++;
        if (k != e) begin
          bad++;
          $display("FAIL nolock_pulse_rise got=%0d want=%0d", k, e);
        end
      end
      if (pll_reset === 1'b0 && prev === 1'b1 && rise > 0) begin
        total++;
        if (k - rise != 4) begin
          bad++;
          $display("FAIL nolock_pulse_width got=%0d want=4", k - rise);
        end
      end
      if (lf < 0 && lock_fail === 1'b1) lf = k;
      if (sys_rst !== 1'b1) rst_lo++;
      prev = pll_reset;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL nolock_pulses_left got=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (lf != 72) begin
      bad++;
      $display("FAIL nolock_lock_fail_edge got=%0d want=72", lf);
    end
    total++;
    if (rst_lo != 0) begin
      bad++;
      $display("FAIL nolock_sys_rst_low got=%0d want=0", rst_lo);
    end
  endtask

  task automatic test_lock_loss;
    int cyc;
    logic [11:0] got;
    start(1'b1);
    wait_ready(60, cyc);
    extlock = 1'b0;
    tick;
    tick;
    total++;
    if ({pll_ready, pll_reset} !== 2'b10) begin
      bad++;
      $display("FAIL loss_n1 got=%b want=10", {pll_ready, pll_reset});
    end
    tick;
    got = {pll_reset, sys_rst, pll_ready, lock_fail, relock_cnt};
    total++;
    if (got !== {4'b1100, 8'd1}) begin
      bad++;
      $display("FAIL loss_n2 got=%h want=%h", got, {4'b1100, 8'd1});
    end
    extlock = 1'b1;
    exp_q.push_back(13);
    wait_ready(60, cyc);
    total++;
    if (cyc != exp_q[0]) begin
      bad++;
      $display("FAIL loss_recover got=%0d want=%0d", cyc, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [11:0] got;
    start(1'b0);
    for (int k = 1; k <= 80; k++) tick;
    extlock = 1'b1;
    wait_ready(100, cyc);
    for (int i = 0; i < 3; i++) begin
      extlock = 1'b0;
      tick;
      tick;
      tick;
      extlock = 1'b1;
      if (i < 2) wait_ready(60, cyc);
    end
    for (int k = 0; k < 7; k++) tick;
    got = {pll_reset, sys_rst, pll_ready, lock_fail, relock_cnt};
    total++;
    if (got !== {4'b0101, 8'd3}) begin
      bad++;
      $display("FAIL mid_pre got=%h want=%h", got, {4'b0101, 8'd3});
    end
    reset = 1'b1;
    tick;
    got = {pll_reset, sys_rst, pll_ready, lock_fail, relock_cnt};
    total++;
    if (got !== {4'b1100, 8'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%h want=%h", got, {4'b1100, 8'd0});
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation;
    int cyc;
    int m = 0;
    int e;
    start(1'b1);
    wait_ready(60, cyc);
    for (int i = 0; i < 260; i++) begin
      extlock = 1'b0;
      m = (m < 255) ? m + 1 : 255;
      exp_q.push_back(m);
      tick;
      tick;
      tick;
      e = exp_q.pop_front();
      total++;
      if (int'(relock_cnt) != e) begin
        bad++;
        $display("FAIL sat_relock_%0d got=%0d want=%0d", i, relock_cnt, e);
      end
      extlock = 1'b1;
      wait_ready(60, cyc);
      total++;
      if (cyc != 13) begin
        bad++;
        $display("FAIL sat_recover_%0d got=%0d want=13", i, cyc);
        break;
      end
    end
    total++;
    if (relock_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_final got=%0d want=255", relock_cnt);
    end
  endtask

  initial begin
    reset   = 1'b1;
    extlock = 1'b0;
    test_reset;
    test_clean_start;
    test_glitch;
    test_no_lock;
    test_lock_loss;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
